dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the far end of the MEM-stage load/store traffic generated from e_m_reg_t (alu_result = address, write_data, mem_write).
- Accepts one word request at a time, holds it for a fixed latency, then returns load data or a store completion.
- Sits beside the core in the simulation top. The hazard unit holds the pipeline via stallF/stallD/stallE from the time a request is issued until data_ok arrives.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- LATENCY, 2: cycles from acceptance to data_ok; at least 1.

Ports:
- clk  input  1  clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = store (SW), 0 = load (LW).
- req_addr  input  32  byte address.
- req_strobe  input  4  byte-lane write enables; ignored for loads.
- req_data  input  32  store data.
- addr_ok  output  1  request accepted this cycle.
- data_ok  output  1  one-cycle completion pulse.
- resp_data  output  32  load data; valid only while data_ok=1.
- err  output  1  misaligned access; valid only while data_ok=1.

Behaviour:
- Reset values: state IDLE, counter 0, data_ok 0, resp_data 0, err 0, captured request cleared. Memory contents are not reset.
- States:
  - IDLE: no request pending.
  - BUSY: request counting down.
  - DONE: completion cycle.
- addr_ok = req_valid && (state==IDLE || state==DONE). This is combinational and is the only combinational output.
- Accept (req_valid && addr_ok in cycle T):
  - Register addr, write, strobe and data.
  - If LATENCY==1, go to DONE; otherwise load counter with LATENCY-1 and go to BUSY.
- BUSY: decrement the counter each cycle. When the counter equals 1, the next state is DONE.
- DONE = cycle T+LATENCY:
  - data_ok=1 and err is driven; outputs are registered, so they are set on entry to DONE.
  - Loads: resp_data = array word as it stands at cycle T+LATENCY, so an earlier store is visible to a later load.
  - Stores: resp_data=0. The array write commits at the rising edge ending the DONE cycle, byte lane i written iff req_strobe[i].
- Leaving DONE: a new request accepted in the DONE cycle begins immediately (back-to-back, with no IDLE bubble); otherwise return to IDLE.
- Word index = req_addr[$clog2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo the depth.
- Store with strobe 4'b0000: no array change; data_ok still pulses.
- req_valid and all other request inputs are don't-care while BUSY. The requester need not hold them after acceptance.
- Reset asserted mid-transaction: the pending request is dropped, no write occurs, and no data_ok pulse is issued.

Optional Feature:
- DMEM_MISALIGN_TRAP_EN defined:
  - Captured addr[1:0]!=0 raises err=1 together with data_ok.
  - Any store is suppressed and resp_data=0.
- Macro undefined:
  - addr[1:0] is ignored and err is tied to 0.
  - The port is always present.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum {IDLE, BUSY, DONE}.
  - dmem_req_t packed struct {addr, write, strobe, data}.
  - Constant DMEM_WORD_BYTES=4.
- Sub-module dmem_array: synchronous byte-strobed write port, combinational read port, parameter DEPTH_WORDS.

Test Plan:
- Reset mid-BUSY: store accepted, reset at T+1 → no data_ok; a later load of that address returns the unchanged value.
- LATENCY=2: SW addr 0x10, data 0xDEADBEEF, strobe 4'hF at T=5 → data_ok at 7 only; then LW 0x10 → resp_data 0xDEADBEEF at acceptance+2.
- Byte strobe: word 0x10 = 0xDEADBEEF, SW data 0x000000AA strobe 4'b0001 → later LW returns 0xDEADBEAA; strobe 4'b0000 → unchanged, data_ok still pulses.
- Back-to-back: LW held valid continuously, LATENCY=1 → addr_ok every cycle from the first, data_ok every cycle, with no gap.
- Wrap: DEPTH_WORDS=1024, SW 0x1000 data 0x12345678 → LW 0x0 returns 0x12345678.
- DMEM_MISALIGN_TRAP_EN: SW addr 0x12 → err=1 with data_ok, memory unchanged. Without the macro: err=0 and word 0x10 written.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

   localparam int DMEM_WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } dmem_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Word array: byte-strobed write committed at the clock edge, combinational read.
// Zero read latency, no backpressure; contents are not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [DMEM_WORD_BYTES-1:0]     strobe,
   input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
   input  logic [31:0]                    wdata,
   input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
         if (we && strobe[i]) begin
            mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: data_ok pulses LATENCY cycles after addr_ok.
// addr_ok only in IDLE/DONE (no queueing); DMEM_MISALIGN_TRAP_EN enables the misaligned-access err.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_strobe,
   input  logic [31:0] req_data,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] resp_data,
   output logic        err
);
   import dmem_pkg::*;

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 1);

   dmem_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   dmem_req_t     req_q, req_nxt, req_in;

   logic          accept, go_done, mem_we;
   logic          fin_write, fin_trap, req_trap;
   logic [31:0]   fin_addr, rdata, fwd_data;
   logic [AW-1:0] raddr, waddr;
   logic          unused_addr_bits;

   assign req_in  = '{addr: req_addr, write: req_write, strobe: req_strobe, data: req_data};
   assign addr_ok = req_valid && (state == IDLE || state == DONE);
   assign accept  = addr_ok;

   // The request finishing at the next edge: the held one while counting down,
   // otherwise (LATENCY==1) the one being accepted right now.
   assign fin_addr  = (state == BUSY) ? req_q.addr  : req_addr;
   assign fin_write = (state == BUSY) ? req_q.write : req_write;
   assign go_done   = (state == BUSY && cnt == CW'(1)) || (LATENCY == 1 && accept);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign req_trap = (req_q.addr[1:0] != 2'b00);
   assign fin_trap = (fin_addr[1:0] != 2'b00);
`else
   assign req_trap = 1'b0;
   assign fin_trap = 1'b0;
`endif

   assign unused_addr_bits = ^{fin_addr[31:AW+2], fin_addr[1:0]};

   assign waddr  = req_q.addr[AW+1:2];
   assign raddr  = fin_addr[AW+1:2];
   assign mem_we = (state == DONE) && req_q.write && !req_trap;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk    (clk),
      .we     (mem_we),
      .strobe (req_q.strobe),
      .waddr  (waddr),
      .wdata  (req_q.data),
      .raddr  (raddr),
      .rdata  (rdata)
   );

   // A store completing this cycle commits on the same edge that registers the
   // next load's data, so merge its bytes in to keep store-to-load ordering.
   always_comb begin
      fwd_data = rdata;
      for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
         if (mem_we && waddr == raddr && req_q.strobe[i]) begin
            fwd_data[8*i +: 8] = req_q.data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_nxt   = req_q;
      case (state)
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (accept) begin
               req_nxt = req_in;
               if (LATENCY == 1) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = BUSY;
                  cnt_nxt   = CW'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         req_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         req_q <= req_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_ok   <= 1'b0;
         err       <= 1'b0;
         resp_data <= '0;
      end else begin
         data_ok   <= go_done;
         err       <= go_done && fin_trap;
         resp_data <= (go_done && !fin_write && !fin_trap) ? fwd_data : '0;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances checked against a queue-style model.
module tb_dmem_responder;

   localparam int DEPTH = 1024;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        valid  [2];
   logic        write  [2];
   logic [31:0] addr   [2];
   logic [3:0]  strobe [2];
   logic [31:0] wdata  [2];
   logic        addr_ok[2];
   logic        data_ok[2];
   logic        err    [2];
   logic [31:0] resp   [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
      .clk(clk), .reset(reset), .req_valid(valid[0]), .req_write(write[0]),
      .req_addr(addr[0]), .req_strobe(strobe[0]), .req_data(wdata[0]),
      .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .resp_data(resp[0]), .err(err[0]));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset), .req_valid(valid[1]), .req_write(write[1]),
      .req_addr(addr[1]), .req_strobe(strobe[1]), .req_data(wdata[1]),
      .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .resp_data(resp[1]), .err(err[1]));

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: one pending request per instance with its due cycle; memory as a word array.
   bit          pend [2];
   int          due  [2];
   logic        pw   [2];
   logic [31:0] pa   [2];
   logic [31:0] pd   [2];
   logic [3:0]  ps   [2];
   logic [31:0] mem_m [2][DEPTH];
   logic        m_aok, m_dok, m_mis;
   logic [31:0] m_resp, m_word;
   int          widx;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) pend[k] = 1'b0;
         m_dok = pend[k] && (due[k] == cyc);
         m_aok = valid[k] && (!pend[k] || m_dok);
         chk($sformatf("addr_ok[%0d]", k), 32'(addr_ok[k]), 32'(m_aok));
         chk($sformatf("data_ok[%0d]", k), 32'(data_ok[k]), 32'(m_dok));
         if (m_dok) begin
            widx   = int'((pa[k] >> 2) % DEPTH);
            m_mis  = TRAP && (pa[k] % 4 != 0);
            m_resp = (pw[k] || m_mis) ? 32'h0 : mem_m[k][widx];
            chk($sformatf("resp[%0d]", k), resp[k], m_resp);
            chk($sformatf("err[%0d]", k), 32'(err[k]), 32'(m_mis));
            if (pw[k] && !m_mis) begin
               m_word = mem_m[k][widx];
               for (int b = 0; b < 4; b++)
                  if (ps[k][b]) m_word[8*b +: 8] = pd[k][8*b +: 8];
               mem_m[k][widx] = m_word;
            end
            pend[k] = 1'b0;
         end
         if (m_aok && !reset) begin
            pend[k] = 1'b1;
            due[k]  = cyc + lat_of(k);
            pw[k]   = write[k];
            pa[k]   = addr[k];
            pd[k]   = wdata[k];
            ps[k]   = strobe[k];
         end
      end
   end

   task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_r, input logic exp_e,
                       input string nm);
      int t0;
      int n;
      @(posedge clk); #1;
      valid[k] = 1'b1; write[k] = w; addr[k] = a; strobe[k] = s; wdata[k] = d;
      @(negedge clk);
      n = 0;
      while (!addr_ok[k] && n < 10) begin @(negedge clk); n++; end
      t0 = cyc;
      @(posedge clk); #1;
      valid[k] = 1'b0;
      @(negedge clk);
      n = 0;
      while (!data_ok[k] && n < 10) begin @(negedge clk); n++; end
      chk({nm, " latency"}, 32'(cyc - t0), 32'(lat_of(k)));
      chk({nm, " resp"}, resp[k], exp_r);
      chk({nm, " err"}, 32'(err[k]), 32'(exp_e));
   endtask

   initial begin
      int n_dok;
      for (int k = 0; k < 2; k++) begin
         valid[k] = 1'b0; write[k] = 1'b0; addr[k] = '0; strobe[k] = '0; wdata[k] = '0;
         pend[k] = 1'b0; due[k] = 0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset data_ok", 32'(data_ok[k]), 32'h0);
         chk("reset resp", resp[k], 32'h0);
         chk("reset err", 32'(err[k]), 32'h0);
      end
      @(posedge clk); #1 reset = 1'b0;

      // LATENCY=2: full store, load back, byte strobes, zero strobe
      xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
      xact(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");
      xact(0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, 32'h0, 1'b0, "sb10");
      xact(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, "lw10 sb");
      xact(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0, "sw10 s0");
      xact(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, "lw10 s0");

      // LATENCY=2 with valid held: accepted in IDLE and in every DONE cycle
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         valid[0] = 1'b1; write[0] = 1'b0; addr[0] = 32'h10;
         @(negedge clk);
         chk("hold2 addr_ok", 32'(addr_ok[0]), 32'(i % 2 == 0));
         chk("hold2 data_ok", 32'(data_ok[0]), 32'(i >= 2 && i % 2 == 0));
         @(posedge clk); #1;
      end
      valid[0] = 1'b0;
      repeat (3) @(negedge clk);

      // address wrap modulo depth
      xact(0, 1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0, 1'b0, "sw1000");
      xact(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h12345678, 1'b0, "lw0 wrap");

      // misaligned store
      xact(0, 1'b1, 32'h10, 4'hF, 32'h11111111, 32'h0, 1'b0, "sw10 pre");
      xact(0, 1'b1, 32'h12, 4'hF, 32'h22222222, 32'h0, TRAP, "sw12");
      xact(0, 1'b0, 32'h10, 4'h0, 32'h0, TRAP ? 32'h11111111 : 32'h22222222, 1'b0, "lw10 mis");

      // reset while BUSY drops the store and its completion
      xact(0, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, "sw20");
      @(posedge clk); #1;
      valid[0] = 1'b1; write[0] = 1'b1; addr[0] = 32'h20; strobe[0] = 4'hF; wdata[0] = 32'h55555555;
      @(negedge clk);
      chk("rst accept", 32'(addr_ok[0]), 32'h1);
      @(posedge clk); #1;
      valid[0] = 1'b0; reset = 1'b1;
      n_dok = 0;
      repeat (2) begin @(negedge clk); if (data_ok[0]) n_dok++; end
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) begin @(negedge clk); if (data_ok[0]) n_dok++; end
      chk("rst data_ok pulses", 32'(n_dok), 32'h0);
      xact(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'h0BADF00D, 1'b0, "lw20 after rst");

      // LATENCY=1: basic, then continuous back-to-back with store-to-load forwarding
      xact(1, 1'b1, 32'h40, 4'hF, 32'hCAFE0001, 32'h0, 1'b0, "l1 sw40");
      xact(1, 1'b0, 32'h40, 4'h0, 32'h0, 32'hCAFE0001, 1'b0, "l1 lw40");
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         valid[1] = 1'b1; write[1] = (i == 0); addr[1] = (i < 2) ? 32'h44 : 32'h40;
         strobe[1] = 4'hF; wdata[1] = 32'hA5A5A5A5;
         @(negedge clk);
         chk("b2b addr_ok", 32'(addr_ok[1]), 32'h1);
         chk("b2b data_ok", 32'(data_ok[1]), 32'(i > 0));
         if (i == 2) chk("b2b fwd resp", resp[1], 32'hA5A5A5A5);
         if (i == 3) chk("b2b lw40 resp", resp[1], 32'hCAFE0001);
         @(posedge clk); #1;
      end
      valid[1] = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
